// File: rtl/imuldiv_div_wb_stage.sv
// imuldiv_div_wb_stage
// Writeback stage behind the iterative divider. An in-order tag FIFO records
// whether each accepted request wants the quotient or the remainder, and the
// destination index. A one-entry output register presents the selected word
// on a val/rdy writeback port at one result per cycle.
// Optional macro IMULDIV_DIVWB_BYPASS_EN: when the output register is empty
// and the consumer is ready, a firing response is forwarded combinationally
// (zero latency). Without the macro the path is purely registered (1 cycle).
module imuldiv_div_wb_stage #(
    parameter int TAG_DEPTH = 2,
    parameter int DST_W     = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tag_push,
    input  logic             tag_sel,
    input  logic [DST_W-1:0] tag_dst,
    output logic             tag_full,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [DST_W-1:0] wb_dst,
    output logic             err
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    // Tag storage; contents are only meaningful between the pointers
    logic             tag_sel_mem [TAG_DEPTH];
    logic [DST_W-1:0] tag_dst_mem [TAG_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tag_full_q, tag_full_d;
    logic             out_full_q, out_full_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [DST_W-1:0] wb_dst_q, wb_dst_d;
    logic             err_q, err_d;

    logic             tag_nonempty;
    logic             resp_rdy;
    logic             resp_fire;
    logic             push_en;
    logic             wb_fire;
    logic             bypass_fire;
    logic             load_en;
    logic             head_sel;
    logic [DST_W-1:0] head_dst;
    logic [31:0]      sel_data;

    // Head-of-queue selection and handshake decode
    always_comb begin
        tag_nonempty = (count_q != '0);
        head_sel     = tag_sel_mem[rd_ptr_q];
        head_dst     = tag_dst_mem[rd_ptr_q];
        sel_data     = head_sel ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
        // A tag pushed this cycle is deliberately invisible here
        resp_rdy     = tag_nonempty && (!out_full_q || wb_rdy);
        resp_fire    = divresp_val && resp_rdy;
        // Full queue may still accept a push when the head is popped
        push_en      = tag_push && (!tag_full_q || resp_fire);
        wb_fire      = out_full_q && wb_rdy;
`ifdef IMULDIV_DIVWB_BYPASS_EN
        bypass_fire  = resp_fire && !out_full_q && wb_rdy;
`else
        bypass_fire  = 1'b0;
`endif
        load_en      = resp_fire && !bypass_fire;
    end

    // Next-state for pointers, occupancy, output register and error flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_full_d = out_full_q;
        wb_data_d  = wb_data_q;
        wb_dst_d   = wb_dst_q;
        err_d      = err_q;

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, resp_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        tag_full_d = (count_d == CNT_W'(TAG_DEPTH));

        if (load_en) begin
            wb_data_d  = sel_data;
            wb_dst_d   = head_dst;
            out_full_d = 1'b1;
        end else if (wb_fire) begin
            out_full_d = 1'b0;
        end

        // Dropped tag or a response with no tag outstanding
        if ((tag_push && tag_full_q && !resp_fire) || (divresp_val && !tag_nonempty)) begin
            err_d = 1'b1;
        end
    end

    // Control and output state with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_full_q <= 1'b0;
            out_full_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_full_q <= tag_full_d;
            out_full_q <= out_full_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            err_q      <= err_d;
        end
    end

    // Tag storage write; no reset needed since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_en) begin
            tag_sel_mem[wr_ptr_q] <= tag_sel;
            tag_dst_mem[wr_ptr_q] <= tag_dst;
        end
    end

    // Output port drive
    always_comb begin
        tag_full    = tag_full_q;
        divresp_rdy = resp_rdy;
        err         = err_q;
`ifdef IMULDIV_DIVWB_BYPASS_EN
        if (out_full_q) begin
            wb_val  = 1'b1;
            wb_data = wb_data_q;
            wb_dst  = wb_dst_q;
        end else if (wb_rdy) begin
            wb_val  = divresp_val && tag_nonempty;
            wb_data = sel_data;
            wb_dst  = head_dst;
        end else begin
            wb_val  = 1'b0;
            wb_data = wb_data_q;
            wb_dst  = wb_dst_q;
        end
`else
        wb_val      = out_full_q;
        wb_data     = wb_data_q;
        wb_dst      = wb_dst_q;
`endif
    end

endmodule

// File: tb/tb_imuldiv_div_wb_stage.sv
// Testbench for imuldiv_div_wb_stage (default registered build).
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the writeback stage.
module tb_imuldiv_div_wb_stage;

    localparam int TAG_DEPTH = 2;
    localparam int DST_W     = 5;

    logic             clk;
    logic             reset_n;
    logic             tag_push;
    logic             tag_sel;
    logic [DST_W-1:0] tag_dst;
    logic             tag_full;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val;
    logic             divresp_rdy;
    logic             wb_val;
    logic             wb_rdy;
    logic [31:0]      wb_data;
    logic [DST_W-1:0] wb_dst;
    logic             err;

    imuldiv_div_wb_stage #(.TAG_DEPTH(TAG_DEPTH), .DST_W(DST_W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tag_push           (tag_push),
        .tag_sel            (tag_sel),
        .tag_dst            (tag_dst),
        .tag_full           (tag_full),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .wb_val             (wb_val),
        .wb_rdy             (wb_rdy),
        .wb_data            (wb_data),
        .wb_dst             (wb_dst),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DST_W:0]   m_tags[$];    // {sel, dst}, oldest first
    logic             m_full;
    logic [31:0]      m_data;
    logic [DST_W-1:0] m_dst;
    logic             m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_tags.delete();
        m_full = 1'b0;
        m_data = '0;
        m_dst  = '0;
        m_err  = 1'b0;
    endtask

    task automatic drive_idle();
        tag_push           = 1'b0;
        tag_sel            = 1'b0;
        tag_dst            = '0;
        divresp_val        = 1'b0;
        divresp_msg_result = '0;
        wb_rdy             = 1'b1;
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model
    task automatic step(input logic p, input logic s, input logic [DST_W-1:0] d,
                        input logic v, input logic [63:0] r, input logic w);
        logic           exp_rdy;
        logic           fire;
        int             size0;
        logic [DST_W:0] t;
        @(negedge clk);
        tag_push           = p;
        tag_sel            = s;
        tag_dst            = d;
        divresp_val        = v;
        divresp_msg_result = r;
        wb_rdy             = w;
        #1;
        size0   = m_tags.size();
        exp_rdy = (size0 != 0) && (!m_full || w);
        check("divresp_rdy", 64'(divresp_rdy), 64'(exp_rdy));
        check("wb_val",      64'(wb_val),      64'(m_full));
        check("wb_data",     64'(wb_data),     64'(m_data));
        check("wb_dst",      64'(wb_dst),      64'(m_dst));
        check("tag_full",    64'(tag_full),    64'(size0 == TAG_DEPTH));
        check("err",         64'(err),         64'(m_err));
        $display("cyc t=%0t push=%0b sel=%0b dst=%0d val=%0b res=%h wb_rdy=%0b -> rdy=%0b wb_val=%0b wb_data=%h wb_dst=%0d",
                 $time, p, s, d, v, r, w, divresp_rdy, wb_val, wb_data, wb_dst);
        fire = v && exp_rdy;
        if (v && size0 == 0) m_err = 1'b1;
        if (fire) begin
            t      = m_tags.pop_front();
            m_data = t[DST_W] ? r[63:32] : r[31:0];
            m_dst  = t[DST_W-1:0];
            m_full = 1'b1;
        end else if (m_full && w) begin
            m_full = 1'b0;
        end
        if (p) begin
            if (size0 == TAG_DEPTH && !fire) m_err = 1'b1;
            else m_tags.push_back({s, d});
        end
    endtask

    // Fixed-value check of the writeback port just after the next edge
    task automatic post_check(input string tag, input logic v, input logic [31:0] data,
                              input logic [DST_W-1:0] dst);
        @(posedge clk);
        #1;
        check({tag, ".wb_val"},  64'(wb_val),  64'(v));
        check({tag, ".wb_data"}, 64'(wb_data), 64'(data));
        check({tag, ".wb_dst"},  64'(wb_dst),  64'(dst));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    localparam logic [63:0] R_A = 64'h0000002e_0000000a;
    localparam logic [63:0] R_B = 64'hffffda72_ffffd353;
    localparam logic [63:0] R_C = 64'h00000001_7fffffff;

    initial begin
        logic [63:0] r;
        logic        p, v;
        drive_idle();
        model_reset();
        reset_n = 1'b0;
        #12;
        check("rst.wb_val",      64'(wb_val),      64'd0);
        check("rst.tag_full",    64'(tag_full),    64'd0);
        check("rst.err",         64'(err),         64'd0);
        check("rst.divresp_rdy", 64'(divresp_rdy), 64'd0);
        check("rst.wb_data",     64'(wb_data),     64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic quotient
        step(1'b1, 1'b0, 5'd3, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, R_A, 1'b1);
        post_check("quot", 1'b1, 32'h0000000a, 5'd3);

        // Remainder
        step(1'b1, 1'b1, 5'd7, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, R_A, 1'b1);
        post_check("rem", 1'b1, 32'h0000002e, 5'd7);

        // Back-to-back responses at full rate
        step(1'b1, 1'b0, 5'd1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 5'd2, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, R_B, 1'b1);
        post_check("b2b0", 1'b1, 32'hffffd353, 5'd1);
        step(1'b0, 1'b0, 5'd0, 1'b1, R_C, 1'b1);
        post_check("b2b1", 1'b1, 32'h00000001, 5'd2);
        step(1'b0, 1'b0, 5'd0, 1'b0, '0, 1'b1);

        // Backpressure: output held, response stalled, released same cycle
        step(1'b1, 1'b0, 5'd4, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 5'd5, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, R_B, 1'b0);
        post_check("bp_load", 1'b1, 32'hffffd353, 5'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 5'd0, 1'b1, R_C, 1'b0);
            check("bp.stall_rdy", 64'(divresp_rdy), 64'd0);
        end
        step(1'b0, 1'b0, 5'd0, 1'b1, R_C, 1'b1);
        check("bp.release_rdy", 64'(divresp_rdy), 64'd1);
        post_check("bp_next", 1'b1, 32'h00000001, 5'd5);
        step(1'b0, 1'b0, 5'd0, 1'b0, '0, 1'b1);

        // Tag full, dropped push, then push+pop while full with wrap
        step(1'b1, 1'b1, 5'd6, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 5'd7, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 5'd8, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        check("full.tag_full", 64'(tag_full), 64'd1);
        check("full.err",      64'(err),      64'd1);
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom};
            step(1'b1, 1'($urandom_range(0, 1)), 5'(10 + i), 1'b1, r, 1'b1);
        end
        // Hold output full, then async reset between edges
        step(1'b0, 1'b0, 5'd0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset.wb_val",   64'(wb_val),   64'd0);
        check("areset.tag_full", 64'(tag_full), 64'd0);
        check("areset.err",      64'(err),      64'd0);
        drive_idle();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic, mostly protocol-legal
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 99) < 55) &&
                (m_tags.size() < TAG_DEPTH || $urandom_range(0, 99) < 10);
            v = ($urandom_range(0, 99) < 60) &&
                (m_tags.size() != 0 || $urandom_range(0, 99) < 2);
            r = {$urandom, $urandom};
            step(p, 1'($urandom_range(0, 1)), 5'($urandom), v, r, 1'($urandom_range(0, 99) < 70));
            if (i == 300) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
